serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default width and FSM encoding.
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell used by the serial adder datapath.
module Full_Adder (
    input  logic ci,
    input  logic a,
    input  logic b,
    output logic co,
    output logic s
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit pair per clock, LSB first, result after WIDTH cycles.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic             load, step, finish;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] res_q;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic             fa_co, fa_s;

    Full_Adder u_fa (
        .ci (carry),
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .co (fa_co),
        .s  (fa_s)
    );

    assign res_nxt = {fa_s, res_q};

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // Operand shifters, carry flop, partial result and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res_q <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            res_q <= '0;
            carry <= ci;
            cnt   <= '0;
        end else if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res_q <= res_nxt[WIDTH-1:1];
            carry <= fa_co;
            if (!finish) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Result registers update only on the completion edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s  <= '0;
            co <= 1'b0;
        end else if (finish) begin
            s  <= res_nxt;
            co <= fa_co;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB is the carry flop while the last bit is being added
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (finish) begin
            ovf <= carry ^ fa_co;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against a countdown/arithmetic reference model.
// Covers the SERIAL_ADDER_OVF_EN build as well when the macro is defined.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         busy, done, co;
    logic [W-1:0] s;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start fixes {co,s}=a+b+ci, delivered W edges later
    int           rem = 0;
    logic [W:0]   m_sum = '0;
    logic         m_v = 1'b0;
    logic         m_busy = 1'b0, m_done = 1'b0, m_co = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_s = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem = 0; m_busy = 0; m_done = 0; m_s = '0; m_co = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_s = m_sum[W-1:0];
                    m_co = m_sum[W];
                    m_ovf = m_v;
                    m_done = 1;
                end
            end else if (start) begin
                m_sum = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
                m_v = (a[W-1] == b[W-1]) && (m_sum[W-1] != a[W-1]);
                rem = W;
            end
            m_busy = (rem > 0);
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", 33'(busy), 33'(m_busy));
        chk("cyc_done", 33'(done), 33'(m_done));
        chk("cyc_s", 33'(s), 33'(m_s));
        chk("cyc_co", 33'(co), 33'(m_co));
`ifdef SERIAL_ADDER_OVF_EN
        chk("cyc_ovf", 33'(ovf), 33'(m_ovf));
`endif
    end

    // One operation with literal expectations; optional start/operand noise at RUN cycle inj
    task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oci,
                      input logic [W-1:0] es, input logic eco, input logic eovf, input int inj);
        int k = 0;
        int busy_cnt = 0;
        bit seen = 0;
        @(negedge clk);
        a = oa; b = ob; ci = oci; start = 1'b1;
        while (!seen && k < 3 * W) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (inj > 0 && k == inj) begin
                start = 1'b1; a = 8'h11; b = 8'h22;
            end
            if (busy) busy_cnt++;
            if (done) seen = 1;
        end
        start = 1'b0;
        chk("op_done_seen", 33'(seen), 33'(1));
        chk("op_latency", 33'(k), 33'(W + 1));
        chk("op_busy_cycles", 33'(busy_cnt), 33'(W));
        chk("op_s", 33'(s), 33'(es));
        chk("op_co", 33'(co), 33'(eco));
`ifdef SERIAL_ADDER_OVF_EN
        chk("op_ovf", 33'(ovf), 33'(eovf));
`else
        if (eovf) k = k;
`endif
        @(negedge clk);
        chk("op_done_single", 33'(done), 33'(0));
    endtask

    logic [W-1:0] bb_a  [3] = '{8'h12, 8'hF0, 8'hAA};
    logic [W-1:0] bb_b  [3] = '{8'h34, 8'h20, 8'h55};
    logic         bb_ci [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] bb_s  [3] = '{8'h46, 8'h11, 8'hFF};
    logic         bb_co [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 33'(busy), 33'(0));
        chk("rst_done", 33'(done), 33'(0));
        chk("rst_s", 33'(s), 33'(0));
        chk("rst_co", 33'(co), 33'(0));
        rst_n = 1'b1;

        op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 0);
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 3);

        // Reset during RUN cycle 5 abandons the operation
        @(negedge clk);
        a = 8'h55; b = 8'h66; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 33'(busy), 33'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 33'(busy), 33'(0));
        chk("async_rst_done", 33'(done), 33'(0));
        chk("async_rst_s", 33'(s), 33'(0));
        chk("async_rst_co", 33'(co), 33'(0));
        repeat (2) @(negedge clk);
        chk("rst_hold_done", 33'(done), 33'(0));
        rst_n = 1'b1;
        op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

        // start held high across DONE: back-to-back operations
        begin
            int idx = 0;
            int last = -1;
            @(negedge clk);
            a = bb_a[0]; b = bb_b[0]; ci = bb_ci[0]; start = 1'b1;
            for (int t = 1; t <= 60 && idx < 3; t++) begin
                @(negedge clk);
                if (done) begin
                    chk("b2b_s", 33'(s), 33'(bb_s[idx]));
                    chk("b2b_co", 33'(co), 33'(bb_co[idx]));
                    if (last >= 0) chk("b2b_gap", 33'(t - last), 33'(W + 1));
                    last = t;
                    idx++;
                    if (idx < 3) begin
                        a = bb_a[idx]; b = bb_b[idx]; ci = bb_ci[idx];
                    end else begin
                        start = 1'b0;
                    end
                end
            end
            start = 1'b0;
            chk("b2b_count", 33'(idx), 33'(3));
        end

`ifdef SERIAL_ADDER_OVF_EN
        op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);
`endif

        // Random traffic: start and operands toggle freely, model tracks acceptance
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom);
            b = W'($urandom);
            ci = 1'($urandom);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
